// File: rtl/parameterized_sar_search_pkg.sv
// Shared definitions for the successive-approximation search controller:
// FSM encodings and a counter-width helper.
package parameterized_sar_search_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [STATE_W-1:0] ST_TRIAL  = 2'd1;
    localparam logic [STATE_W-1:0] ST_SAMPLE = 2'd2;
    localparam logic [STATE_W-1:0] ST_DONE   = 2'd3;

    // $clog2 that never returns less than one bit, so single-value counters stay legal.
    function automatic int clog2_min1(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/parameterized_sar_search.sv
// SAR search controller: drives trial operands to an external comparator and
// resolves the largest value <= target, MSB first, with optional settle cycles.
module parameterized_sar_search
    import parameterized_sar_search_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int SETTLE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_lt,
    input  logic             cmp_eq,
    input  logic             cmp_gt,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             exact,
    output logic             err
);

    localparam int BW = $clog2(WIDTH);
    localparam int SW = clog2_min1(SETTLE + 1);
    localparam logic [BW-1:0]    MSB_IDX     = BW'(WIDTH - 1);
    localparam logic [SW-1:0]    SETTLE_LOAD = SW'(SETTLE);
    localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [BW-1:0]      bit_q, bit_d;
    logic [SW-1:0]      settle_q, settle_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   guess_q, guess_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               exact_q, exact_d;
    logic               err_q, err_d;

    logic [STATE_W-1:0] phase;
    logic [WIDTH-1:0]   mask;
    logic [WIDTH-1:0]   acc_sampled;
    logic               flags_legal;
    logic               hit;

    always_comb begin
        // The last settle cycle of a trial is its sample point, so the search
        // never spends a separate clock in SAMPLE.
        phase = state_q;
        if (state_q == ST_TRIAL && settle_q == '0) begin
            phase = ST_SAMPLE;
        end

        mask        = ONE << bit_q;
        flags_legal = $onehot({cmp_lt, cmp_eq, cmp_gt});
        hit         = flags_legal && cmp_eq;
        acc_sampled = (flags_legal && (cmp_lt || cmp_eq)) ? (acc_q | mask) : acc_q;

        state_d  = state_q;
        bit_d    = bit_q;
        settle_d = settle_q;
        acc_d    = acc_q;
        guess_d  = guess_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = done_q;
        exact_d  = exact_q;
        err_d    = err_q;

        case (phase)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_TRIAL;
                    bit_d    = MSB_IDX;
                    settle_d = SETTLE_LOAD;
                    acc_d    = '0;
                    guess_d  = ONE << MSB_IDX;
                    err_d    = 1'b0;
                    exact_d  = 1'b0;
                    done_d   = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            ST_TRIAL: begin
                settle_d = settle_q - 1'b1;
            end
            ST_SAMPLE: begin
                acc_d = acc_sampled;
                err_d = err_q | ~flags_legal;
                if (hit || bit_q == '0) begin
                    state_d  = ST_DONE;
                    result_d = acc_sampled;
                    guess_d  = acc_sampled;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    exact_d  = hit;
                end else begin
                    state_d  = ST_TRIAL;
                    bit_d    = bit_q - 1'b1;
                    settle_d = SETTLE_LOAD;
                    guess_d  = acc_sampled | (mask >> 1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            bit_q    <= '0;
            settle_q <= '0;
            acc_q    <= '0;
            guess_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            exact_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            settle_q <= settle_d;
            acc_q    <= acc_d;
            guess_q  <= guess_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            exact_q  <= exact_d;
            err_q    <= err_d;
        end
    end

    assign guess  = guess_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign exact  = exact_q;
    assign err    = err_q;

endmodule

// File: tb/tb_parameterized_sar_search.sv
// Scoreboard bench: two controller instances (16-bit/no settle, 32-bit/settle 2)
// each paired with a behavioural comparator; a reference model predicts each search.
module tb_parameterized_sar_search;

    localparam int WA = 16;
    localparam int SA = 0;
    localparam int WB = 32;
    localparam int SB = 2;

    typedef struct {
        logic [31:0] result;
        logic        exact;
        logic        err;
        int          lat;
        int          start_cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t qa[$];
    exp_t qb[$];

    // Instance A: 16-bit, SETTLE=0, with an illegal-flag override
    logic          start_a = 1'b0, force_ill_a = 1'b0;
    logic [WA-1:0] target_a = '0;
    logic          lt_a, eq_a, gt_a;
    logic [WA-1:0] guess_a, result_a;
    logic          busy_a, done_a, exact_a, err_a;

    always_comb begin
        lt_a = (guess_a < target_a);
        eq_a = (guess_a == target_a);
        gt_a = (guess_a > target_a);
        if (force_ill_a) begin
            lt_a = 1'b1;
            eq_a = 1'b0;
            gt_a = 1'b1;
        end
    end

    parameterized_sar_search #(.WIDTH(WA), .SETTLE(SA)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .cmp_lt(lt_a), .cmp_eq(eq_a), .cmp_gt(gt_a),
        .guess(guess_a), .busy(busy_a), .done(done_a),
        .result(result_a), .exact(exact_a), .err(err_a)
    );

    // Instance B: 32-bit, SETTLE=2
    logic          start_b = 1'b0;
    logic [WB-1:0] target_b = '0;
    logic          lt_b, eq_b, gt_b;
    logic [WB-1:0] guess_b, result_b;
    logic          busy_b, done_b, exact_b, err_b;

    always_comb begin
        lt_b = (guess_b < target_b);
        eq_b = (guess_b == target_b);
        gt_b = (guess_b > target_b);
    end

    parameterized_sar_search #(.WIDTH(WB), .SETTLE(SB)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .cmp_lt(lt_b), .cmp_eq(eq_b), .cmp_gt(gt_b),
        .guess(guess_b), .busy(busy_b), .done(done_b),
        .result(result_b), .exact(exact_b), .err(err_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: a correct search lands exactly on the target, stopping at the trial
    // of its lowest set bit. An illegal first sample clears the MSB regardless of the target.
    function automatic exp_t model(input logic [31:0] target, input int width, input int settle,
                                   input bit ill0, input int start_cyc);
        exp_t        e;
        int          tz;
        logic [31:0] msb;
        msb         = 32'd1 << (width - 1);
        e.err       = ill0;
        e.start_cyc = start_cyc;
        if (ill0 && ((target & msb) != 0)) begin
            e.result = msb - 1;
            e.exact  = 1'b0;
            e.lat    = width * (settle + 1);
        end else if (target == 0) begin
            e.result = 0;
            e.exact  = 1'b0;
            e.lat    = width * (settle + 1);
        end else begin
            tz = 0;
            for (int i = width - 1; i >= 0; i--) begin
                if (target[i]) tz = i;
            end
            e.result = target;
            e.exact  = 1'b1;
            e.lat    = (width - tz) * (settle + 1);
        end
        return e;
    endfunction

    // Monitor A
    initial begin : mon_a
        logic          prev_done, prev_busy;
        logic [WA-1:0] prev_guess;
        int            run;
        exp_t          e;
        prev_done = 0; prev_busy = 0; prev_guess = '0; run = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_done = 0; prev_busy = 0; run = 0;
                continue;
            end
            if (busy_a) begin
                if (prev_busy && guess_a == prev_guess) run++;
                else begin
                    if (prev_busy) chk("a_guess_hold", run, SA + 1);
                    run = 1;
                end
            end
            if (qa.size() != 0 && cyc >= qa[0].start_cyc && !done_a)
                chk("a_busy", busy_a, 1);
            if (done_a && !prev_done) begin
                if (qa.size() == 0) chk("a_unexpected_done", 1, 0);
                else begin
                    e = qa.pop_front();
                    chk("a_result",  {16'b0, result_a}, e.result);
                    chk("a_exact",   exact_a, e.exact);
                    chk("a_err",     err_a, e.err);
                    chk("a_latency", cyc - e.start_cyc, e.lat);
                    chk("a_busy_at_done", busy_a, 0);
                end
            end
            prev_done  = done_a;
            prev_busy  = busy_a;
            prev_guess = guess_a;
        end
    end

    // Monitor B
    initial begin : mon_b
        logic          prev_done, prev_busy;
        logic [WB-1:0] prev_guess;
        int            run;
        exp_t          e;
        prev_done = 0; prev_busy = 0; prev_guess = '0; run = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_done = 0; prev_busy = 0; run = 0;
                continue;
            end
            if (busy_b) begin
                if (prev_busy && guess_b == prev_guess) run++;
                else begin
                    if (prev_busy) chk("b_guess_hold", run, SB + 1);
                    run = 1;
                end
            end
            if (qb.size() != 0 && cyc >= qb[0].start_cyc && !done_b)
                chk("b_busy", busy_b, 1);
            if (done_b && !prev_done) begin
                if (qb.size() == 0) chk("b_unexpected_done", 1, 0);
                else begin
                    e = qb.pop_front();
                    chk("b_result",  result_b, e.result);
                    chk("b_exact",   exact_b, e.exact);
                    chk("b_err",     err_b, e.err);
                    chk("b_latency", cyc - e.start_cyc, e.lat);
                    chk("b_busy_at_done", busy_b, 0);
                end
            end
            prev_done  = done_b;
            prev_busy  = busy_b;
            prev_guess = guess_b;
        end
    end

    task automatic run_a(input logic [WA-1:0] t, input bit ill, input int pulse_at);
        target_a    = t;
        force_ill_a = ill;
        start_a     = 1'b1;
        qa.push_back(model({16'b0, t}, WA, SA, ill, cyc + 1));
        @(negedge clk);
        start_a = 1'b0;
        chk("a_done_drops", done_a, 0);
        @(negedge clk);
        force_ill_a = 1'b0;
        for (int i = 0; i < WA * (SA + 1) + 8 && qa.size() != 0; i++) begin
            start_a = (i == pulse_at);
            @(negedge clk);
        end
        start_a = 1'b0;
        chk("a_timeout", qa.size(), 0);
        qa.delete();
        $display("[TB] A target=%04h ill=%0d -> result=%04h exact=%0d err=%0d", t, ill, result_a, exact_a, err_a);
    endtask

    task automatic run_b(input logic [WB-1:0] t);
        target_b = t;
        start_b  = 1'b1;
        qb.push_back(model(t, WB, SB, 1'b0, cyc + 1));
        @(negedge clk);
        start_b = 1'b0;
        chk("b_done_drops", done_b, 0);
        for (int i = 0; i < WB * (SB + 1) + 8 && qb.size() != 0; i++) @(negedge clk);
        chk("b_timeout", qb.size(), 0);
        qb.delete();
        $display("[TB] B target=%08h -> result=%08h exact=%0d err=%0d", t, result_b, exact_b, err_b);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_guess_a"},  {16'b0, guess_a}, 0);
        chk({tag, "_result_a"}, {16'b0, result_a}, 0);
        chk({tag, "_flags_a"},  {busy_a, done_a, exact_a, err_a}, 0);
        chk({tag, "_guess_b"},  guess_b, 0);
        chk({tag, "_result_b"}, result_b, 0);
        chk({tag, "_flags_b"},  {busy_b, done_b, exact_b, err_b}, 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [WA-1:0] ta;
        logic [WB-1:0] tb;
        logic [WA-1:0] specials [4];
        specials[0] = 16'h0000; specials[1] = 16'hFFFF;
        specials[2] = 16'h8000; specials[3] = 16'h0001;

        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_a(16'h0019, 1'b0, -1);
        run_a(16'h8000, 1'b0, -1);
        run_a(16'h0000, 1'b0, -1);
        run_a(16'h0025, 1'b0, 3);
        run_a(16'hFFFF, 1'b1, -1);
        run_a(16'hFFFF, 1'b0, -1);
        run_b(32'h00000191);
        run_b(32'h00000000);
        run_b(32'hFFFFFFFF);

        // Asynchronous reset in the middle of a search
        target_a = 16'h0019;
        start_a  = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        qa.delete();
        #1 chk_all_zero("midrst");
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        run_a(16'h0019, 1'b0, -1);

        for (int n = 0; n < 40; n++) begin
            ta = WA'($urandom());
            if ($urandom_range(0, 7) == 0) ta = specials[$urandom_range(0, 3)];
            run_a(ta, ($urandom_range(0, 5) == 0), -1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        for (int n = 0; n < 12; n++) begin
            tb = WB'($urandom());
            if ($urandom_range(0, 3) == 0) tb = tb >> $urandom_range(0, 31);
            run_b(tb);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
